bram_sdp_be: RTL

//  Simple dual-port block RAM: one write port with byte enables, one read port, single clock.

---
 rtl/bram_sdp_be.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bram_sdp_be.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_sdp_be
//  Purpose  : Simple dual-port block RAM, single clock, one byte-enabled
//             write port and one read port. After reset an internal
//             sequencer zeroes every word (optional), a read-valid strobe
//             accompanies each read and an optional extra output register
//             lengthens the read pipeline by one cycle.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1          clock, all logic on posedge
//    resetb   in   1          asynchronous active-low reset
//    wr_en    in   1          write request
//    wr_be    in   NB         byte enables, bit b -> wr_data[8b+7:8b]
//    wr_addr  in   DEPTH_LOG  write word address
//    wr_data  in   WIDTH      write data
//    rd_en    in   1          read request
//    rd_addr  in   DEPTH_LOG  read word address
//    rd_data  out  WIDTH      read data, meaningful when rd_valid=1
//    rd_valid out  1          one-cycle strobe per accepted read
//    busy     out  1          zero-clear in progress, requests ignored
// ============================================================================
module bram_sdp_be #(
  parameter int DEPTH          = 256,
  parameter int DEPTH_LOG      = 8,
  parameter int WIDTH          = 32,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 wr_en,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [DEPTH_LOG-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [DEPTH_LOG-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic                 busy
);

  localparam int NB = WIDTH / 8;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_t               state;
  state_t               state_nxt;
  logic [DEPTH_LOG-1:0] clr_cnt;
  logic [DEPTH_LOG-1:0] clr_cnt_nxt;
  logic                 clearing;
  logic                 ready;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clearing    = 1'b0;
    ready       = 1'b0;
    case (state)
      S_CLEAR: begin
        clearing    = 1'b1;
        clr_cnt_nxt = clr_cnt + DEPTH_LOG'(1);
        if (clr_cnt == DEPTH_LOG'(DEPTH - 1)) begin
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
  end

  assign busy = (state == S_CLEAR);

  // --------------------------------------------------------------------------
  // Memory lanes: one 8-bit wide array per byte so each lane has a plain
  // single write enable; the clear sequencer borrows the write port.
  // --------------------------------------------------------------------------
  logic             wr_go;
  logic             rd_go;
  logic [NB-1:0]    byp_mask;
  logic [WIDTH-1:0] byp_data;
  logic [WIDTH-1:0] merged;
  logic             v1;

  assign wr_go = ready & wr_en;
  assign rd_go = ready & rd_en;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0]           lane_mem [DEPTH];
    logic [7:0]           lane_raw;
    logic                 lane_we;
    logic [DEPTH_LOG-1:0] lane_addr;
    logic [7:0]           lane_wdata;

    assign lane_we    = clearing | (wr_go & wr_be[b]);
    assign lane_addr  = clearing ? clr_cnt : wr_addr;
    assign lane_wdata = clearing ? 8'h00 : wr_data[8*b +: 8];

    always_ff @(posedge clk) begin
      if (lane_we) begin
        lane_mem[lane_addr] <= lane_wdata;
      end
    end

    // Raw read returns the pre-write contents; write-first is applied below.
    always_ff @(posedge clk) begin
      if (rd_go) begin
        lane_raw <= lane_mem[rd_addr];
      end
    end

    assign merged[8*b +: 8] = byp_mask[b] ? byp_data[8*b +: 8] : lane_raw;
  end

  // Same-address write on the read edge: remember which bytes were written
  // and their new values so the output can substitute them per byte.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      v1       <= 1'b0;
      byp_mask <= '0;
      byp_data <= '0;
    end else begin
      v1 <= rd_go;
      if (rd_go) begin
        byp_mask <= (wr_go && (wr_addr == rd_addr)) ? wr_be : '0;
        byp_data <= wr_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage; rd_data only updates on a valid read so it holds otherwise.
  // --------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] pipe_data;
    logic             pipe_v;

    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        pipe_data <= '0;
        pipe_v    <= 1'b0;
        rd_data   <= '0;
        rd_valid  <= 1'b0;
      end else begin
        pipe_v   <= v1;
        rd_valid <= pipe_v;
        if (v1) begin
          pipe_data <= merged;
        end
        if (pipe_v) begin
          rd_data <= pipe_data;
        end
      end
    end
  end else begin : g_out_direct
    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= v1;
        if (v1) begin
          rd_data <= merged;
        end
      end
    end
  end

endmodule
`default_nettype wire
